computer_nbit: RTL and testbench
================================

COMPUTER_NBIT -- requirements
Module: computer_nbit

Interface
REQ-001 SHALL have parameter DATA_W, default 4: width of accumulator A, register B, data memory words and d_in/d_out.
REQ-002 SHALL have parameter ADDR_W, default 4: address width of the instruction memory, data memory, PC and stack entries; both memories have 2^ADDR_W entries.
REQ-003 SHALL have parameter STACK_DEPTH, default 16, legal range >=1: number of return-address stack entries.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset and program-load enable; synchronous, active-high.
REQ-006 SHALL have port d_in, input, DATA_W, data word written to data memory during load.
REQ-007 SHALL have port ins_address, input, ADDR_W, load address for both memories.
REQ-008 SHALL have port ins, input, ADDR_W+4, instruction word written during load; [ADDR_W+3:4] = operand address, [3:0] = opcode.
REQ-009 SHALL have port d_out, output, DATA_W, registered output port.
REQ-010 SHALL have port ZF, output, 1, zero flag.
REQ-011 SHALL have port CF, output, 1, carry/borrow flag.
REQ-012 SHALL have port halted, output, 1, high once execution has stopped.
REQ-013 SHALL have port stack_err, output, 1, sticky stack overflow/underflow indication.

Function
REQ-014 Each rising edge with rst=1 SHALL write ins to instruction memory[ins_address] and d_in to data memory[ins_address]; memories are not otherwise cleared.
REQ-015 Each rising edge with rst=0 and halted=0 SHALL fetch instruction memory[PC] and complete that instruction in that single edge (one instruction per clock).
REQ-016 Default PC update SHALL be PC+1 modulo 2^ADDR_W (address 2^ADDR_W-1 wraps to 0).
REQ-017 Opcodes (addr = operand field): 0 NOP; 1 MOV_A_ADDR A=dmem[addr]; 2 XCHG_B_A swap A,B; 3 ADD_A_B; 4 OUT_A d_out=A; 5 INC_A; 6 MOV_B_ADDR B=dmem[addr]; 7 SUB_A_B; 8 STORE_A_ADDR dmem[addr]=A; 9 JMP PC=addr; A JZ PC=addr if ZF=1; B JC PC=addr if CF=1; C CALL_ADDRESS; D RET; E AND_A_B; F HLT.
REQ-018 ADD SHALL compute {CF,A}=A+B over DATA_W+1 bits; INC the same with B replaced by 1; SUB SHALL set A=A-B modulo 2^DATA_W with CF=1 iff A<B; AND SHALL set A=A&B and CF=0.
REQ-019 ZF SHALL be set to (new A==0) by opcodes 3,5,7,E only; all other opcodes SHALL leave ZF and CF unchanged.
REQ-020 d_out SHALL change only on OUT_A and hold otherwise.
REQ-021 CALL with SP<STACK_DEPTH SHALL store PC+1 (wrapped) at stack[SP], increment SP, set PC=addr.
REQ-022 RET with SP>0 SHALL decrement SP and set PC=stack[SP-1].
REQ-023 CALL with SP==STACK_DEPTH (overflow) or RET with SP==0 (underflow) SHALL leave PC, SP and the stack unchanged, and set stack_err=1 and halted=1.
REQ-024 HLT SHALL set halted=1 with PC held at the HLT address; while halted=1, no register, flag, memory or output changes until rst.
REQ-025 A conditional jump not taken SHALL behave as NOP.

Reset
REQ-026 Any rising edge with rst=1 SHALL set PC=0, SP=0, A=0, B=0, d_out=0, ZF=0, CF=0, halted=0, stack_err=0, including when asserted mid-program or while halted.
REQ-027 First instruction executed SHALL be instruction memory[0], on the first rising edge with rst=0.

Verification
REQ-028 Defaults; load imem[0..6]=16,02,5C,04,0F,05,0D, dmem[1]=3; release rst -> edge1 B=3, edge2 A=3 B=0, edge3 PC=5 SP=1, edge4 A=4, edge5 PC=3 SP=0, edge6 d_out=4, edge7 halted=1; d_out stays 4, ZF=0, CF=0.
REQ-029 Defaults; A=F then INC_A then JC 9 -> A=0, CF=1, ZF=1, next PC=9; same with A=E -> CF=0, ZF=0, PC falls through.
REQ-030 STACK_DEPTH=2; three nested CALLs -> after third CALL edge stack_err=1, halted=1, SP=2, PC = third CALL address; RET as first instruction -> stack_err=1, SP=0.
REQ-031 DATA_W=8, ADDR_W=5; dmem values 200 and 100, MOV_A, MOV_B, ADD -> A=44, CF=1, ZF=0; SUB 44-100 -> A=200, CF=1; NOP at address 31 -> PC wraps to 0.
REQ-032 Assert rst for one edge mid-program (after d_out=4 in REQ-028 run) -> all outputs 0 next edge; release -> identical program replay, d_out=4 on edge6, proving memory retained.
REQ-033 STORE_A_ADDR then MOV_B_ADDR same address on next edge -> B equals stored A (write visible on following instruction).

Source files
------------

// File: rtl/computer_nbit.sv
// rtl/computer_nbit.sv - single-cycle accumulator computer with loadable instruction/data memories
// One instruction completes per clock; rst doubles as the program-load strobe for both memories.
module computer_nbit #(
   parameter int DATA_W      = 4,
   parameter int ADDR_W      = 4,
   parameter int STACK_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] d_in,
   input  logic [ADDR_W-1:0] ins_address,
   input  logic [ADDR_W+3:0] ins,
   output logic [DATA_W-1:0] d_out,
   output logic              ZF,
   output logic              CF,
   output logic              halted,
   output logic              stack_err
);
   localparam int MEM_N = 1 << ADDR_W;
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0, OP_MOV_A = 4'h1, OP_XCHG  = 4'h2, OP_ADD   = 4'h3,
      OP_OUT   = 4'h4, OP_INC   = 4'h5, OP_MOV_B = 4'h6, OP_SUB   = 4'h7,
      OP_STORE = 4'h8, OP_JMP   = 4'h9, OP_JZ    = 4'hA, OP_JC    = 4'hB,
      OP_CALL  = 4'hC, OP_RET   = 4'hD, OP_AND   = 4'hE, OP_HLT   = 4'hF
   } opcode_t;

   logic [ADDR_W+3:0] r_imem  [MEM_N];
   logic [DATA_W-1:0] r_dmem  [MEM_N];
   logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

   logic [ADDR_W-1:0] r_pc;
   logic [SP_W-1:0]   r_sp;
   logic [DATA_W-1:0] r_a, r_b, r_dout;
   logic              r_zf, r_cf, r_halted, r_stack_err;

   logic [ADDR_W+3:0] w_ins;
   opcode_t           w_op;
   logic [ADDR_W-1:0] w_addr, w_pc_inc;
   logic [DATA_W-1:0] w_dm_rd;
   logic [DATA_W:0]   w_sum, w_inc;
   logic [IDX_W-1:0]  w_push_idx, w_pop_idx;

   assign w_ins      = r_imem[r_pc];
   assign w_op       = opcode_t'(w_ins[3:0]);
   assign w_addr     = w_ins[ADDR_W+3:4];
   assign w_pc_inc   = r_pc + ADDR_W'(1);
   assign w_dm_rd    = r_dmem[w_addr];
   assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
   assign w_inc      = {1'b0, r_a} + (DATA_W+1)'(1);
   assign w_push_idx = IDX_W'(r_sp);
   assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_imem[ins_address] <= ins;
         r_dmem[ins_address] <= d_in;
         r_pc        <= '0;
         r_sp        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_dout      <= '0;
         r_zf        <= 1'b0;
         r_cf        <= 1'b0;
         r_halted    <= 1'b0;
         r_stack_err <= 1'b0;
      end else if (!r_halted) begin
         r_pc <= w_pc_inc;
         case (w_op)
            OP_MOV_A: r_a <= w_dm_rd;
            OP_XCHG: begin
               r_a <= r_b;
               r_b <= r_a;
            end
            OP_ADD: begin
               {r_cf, r_a} <= w_sum;
               r_zf        <= (w_sum[DATA_W-1:0] == '0);
            end
            OP_OUT: r_dout <= r_a;
            OP_INC: begin
               {r_cf, r_a} <= w_inc;
               r_zf        <= (w_inc[DATA_W-1:0] == '0);
            end
            OP_MOV_B: r_b <= w_dm_rd;
            OP_SUB: begin
               r_a  <= r_a - r_b;
               r_cf <= (r_a < r_b);
               r_zf <= (r_a == r_b);
            end
            OP_STORE: r_dmem[w_addr] <= r_a;
            OP_JMP:   r_pc <= w_addr;
            OP_JZ:    if (r_zf) r_pc <= w_addr;
            OP_JC:    if (r_cf) r_pc <= w_addr;
            OP_CALL: begin
               // Overflow freezes the machine at the offending CALL
               if (r_sp == SP_FULL) begin
                  r_pc        <= r_pc;
                  r_halted    <= 1'b1;
                  r_stack_err <= 1'b1;
               end else begin
                  r_stack[w_push_idx] <= w_pc_inc;
                  r_sp                <= r_sp + SP_W'(1);
                  r_pc                <= w_addr;
               end
            end
            OP_RET: begin
               if (r_sp == '0) begin
                  r_pc        <= r_pc;
                  r_halted    <= 1'b1;
                  r_stack_err <= 1'b1;
               end else begin
                  r_sp <= r_sp - SP_W'(1);
                  r_pc <= r_stack[w_pop_idx];
               end
            end
            OP_AND: begin
               r_a  <= r_a & r_b;
               r_cf <= 1'b0;
               r_zf <= ((r_a & r_b) == '0);
            end
            OP_HLT: begin
               r_pc     <= r_pc;
               r_halted <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign d_out     = r_dout;
   assign ZF        = r_zf;
   assign CF        = r_cf;
   assign halted    = r_halted;
   assign stack_err = r_stack_err;
endmodule

// File: tb/tb_computer_nbit.sv
// tb/tb_computer_nbit.sv - self-checking bench for computer_nbit (three parameterisations)
module tb_computer_nbit;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
   logic [3:0] din0 = '0, din1 = '0;
   logic [7:0] din2 = '0;
   logic [3:0] ia0 = '0, ia1 = '0;
   logic [4:0] ia2 = '0;
   logic [7:0] ins0 = '0, ins1 = '0;
   logic [8:0] ins2 = '0;
   logic [3:0] dout0, dout1;
   logic [7:0] dout2;
   logic zf0, cf0, h0, se0, zf1, cf1, h1, se1, zf2, cf2, h2, se2;

   computer_nbit dut0 (.clk(clk), .rst(rst0), .d_in(din0), .ins_address(ia0), .ins(ins0),
      .d_out(dout0), .ZF(zf0), .CF(cf0), .halted(h0), .stack_err(se0));
   computer_nbit #(.STACK_DEPTH(2)) dut1 (.clk(clk), .rst(rst1), .d_in(din1), .ins_address(ia1),
      .ins(ins1), .d_out(dout1), .ZF(zf1), .CF(cf1), .halted(h1), .stack_err(se1));
   computer_nbit #(.DATA_W(8), .ADDR_W(5)) dut2 (.clk(clk), .rst(rst2), .d_in(din2), .ins_address(ia2),
      .ins(ins2), .d_out(dout2), .ZF(zf2), .CF(cf2), .halted(h2), .stack_err(se2));

   int n_vec = 0, n_err = 0;
   int pim[32], pdm[32];

   typedef struct {
      string name;
      int pc, sp, a, b, dout, zf, cf, halt;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 32; i++) begin
         pim[i] = 0;
         pdm[i] = 0;
      end
   endtask

   // Loading leaves rst high on the final edge, so the machine is also reset.
   task automatic load0();
      rst0 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ia0 = 4'(i); ins0 = 8'(pim[i]); din0 = 4'(pdm[i]);
         tick();
      end
   endtask

   task automatic load1();
      rst1 = 1'b1;
      for (int i = 0; i < 16; i++) begin
         ia1 = 4'(i); ins1 = 8'(pim[i]); din1 = 4'(pdm[i]);
         tick();
      end
   endtask

   task automatic load2();
      rst2 = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ia2 = 5'(i); ins2 = 9'(pim[i]); din2 = 8'(pdm[i]);
         tick();
      end
   endtask

   function automatic longint pack0(int pc, int sp, int a, int b, int d, int z, int c, int h);
      return (longint'(pc) << 24) | (longint'(sp) << 16) | (longint'(a) << 12) | (longint'(b) << 8)
           | (longint'(d) << 4) | (longint'(z) << 2) | (longint'(c) << 1) | longint'(h);
   endfunction

   task automatic run_table(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         tick();
         chk({tag, tbl[k].name},
             pack0(int'(dut0.r_pc), int'(dut0.r_sp), int'(dut0.r_a), int'(dut0.r_b),
                   int'(dout0), int'(zf0), int'(cf0), int'(h0)),
             pack0(tbl[k].pc, tbl[k].sp, tbl[k].a, tbl[k].b, tbl[k].dout,
                   tbl[k].zf, tbl[k].cf, tbl[k].halt));
      end
   endtask

   // Reference model: instruction-level interpreter over plain integers.
   int m_pc, m_sp, m_a, m_b, m_dout, m_zf, m_cf, m_halt, m_serr;
   int m_im[16], m_dm[16], m_stk[16];

   task automatic model_reset();
      m_pc = 0; m_sp = 0; m_a = 0; m_b = 0; m_dout = 0;
      m_zf = 0; m_cf = 0; m_halt = 0; m_serr = 0;
   endtask

   task automatic model_step();
      int op, ad, npc, s;
      if (m_halt != 0) return;
      op  = m_im[m_pc] % 16;
      ad  = m_im[m_pc] / 16;
      npc = (m_pc + 1) % 16;
      case (op)
         1:  m_a = m_dm[ad];
         2:  begin s = m_a; m_a = m_b; m_b = s; end
         3:  begin s = m_a + m_b; m_a = s % 16; m_cf = (s > 15); m_zf = (m_a == 0); end
         4:  m_dout = m_a;
         5:  begin s = m_a + 1; m_a = s % 16; m_cf = (s > 15); m_zf = (m_a == 0); end
         6:  m_b = m_dm[ad];
         7:  begin m_cf = (m_a < m_b); m_a = (m_a - m_b + 16) % 16; m_zf = (m_a == 0); end
         8:  m_dm[ad] = m_a;
         9:  npc = ad;
         10: if (m_zf != 0) npc = ad;
         11: if (m_cf != 0) npc = ad;
         12: if (m_sp == 16) begin m_halt = 1; m_serr = 1; npc = m_pc; end
             else begin m_stk[m_sp] = npc; m_sp++; npc = ad; end
         13: if (m_sp == 0) begin m_halt = 1; m_serr = 1; npc = m_pc; end
             else begin m_sp--; npc = m_stk[m_sp]; end
         14: begin m_a = m_a & m_b; m_cf = 0; m_zf = (m_a == 0); end
         15: begin m_halt = 1; npc = m_pc; end
         default: ;
      endcase
      m_pc = npc;
   endtask

   initial begin
      // Call/return program with expected state after each edge.
      tbl[0] = '{"e1_movb", 1, 0, 0, 3, 0, 0, 0, 0};
      tbl[1] = '{"e2_xchg", 2, 0, 3, 0, 0, 0, 0, 0};
      tbl[2] = '{"e3_call", 5, 1, 3, 0, 0, 0, 0, 0};
      tbl[3] = '{"e4_inc",  6, 1, 4, 0, 0, 0, 0, 0};
      tbl[4] = '{"e5_ret",  3, 0, 4, 0, 0, 0, 0, 0};
      tbl[5] = '{"e6_out",  4, 0, 4, 0, 4, 0, 0, 0};
      tbl[6] = '{"e7_hlt",  4, 0, 4, 0, 4, 0, 0, 1};
      tbl[7] = '{"e8_held", 4, 0, 4, 0, 4, 0, 0, 1};

      clear_prog();
      pim[0] = 'h16; pim[1] = 'h02; pim[2] = 'h5C; pim[3] = 'h04;
      pim[4] = 'h0F; pim[5] = 'h05; pim[6] = 'h0D; pdm[1] = 3;
      load0();
      chk("reset_outs", {dout0, zf0, cf0, h0, se0}, 8'h00);
      rst0 = 1'b0;
      run_table(6, "prog_");
      rst0 = 1'b1;
      tick();
      chk("midrst_state", {dut0.r_pc, dut0.r_a, dut0.r_b, dout0, zf0, cf0, h0, se0}, 20'h0);
      rst0 = 1'b0;
      run_table(8, "replay_");
      chk("halt_stackerr", se0, 1'b0);

      // INC overflow feeding JC, then the non-carry variant.
      for (int v = 0; v < 2; v++) begin
         clear_prog();
         pdm[0] = (v == 0) ? 15 : 14;
         pim[0] = 'h01; pim[1] = 'h05; pim[2] = 'h9B; pim[3] = 'h0F; pim[9] = 'h0F;
         load0();
         rst0 = 1'b0;
         tick(); tick(); tick();
         if (v == 0) chk("inc_wrap_jc", {dut0.r_a, zf0, cf0, dut0.r_pc}, {4'h0, 1'b1, 1'b1, 4'h9});
         else        chk("inc_nc_fall", {dut0.r_a, zf0, cf0, dut0.r_pc}, {4'hF, 1'b0, 1'b0, 4'h3});
      end

      // STORE then MOV_B from the same address on the next instruction.
      clear_prog();
      pdm[3] = 9;
      pim[0] = 'h31; pim[1] = 'h05; pim[2] = 'h78; pim[3] = 'h76; pim[4] = 'h0F;
      load0();
      rst0 = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("store_then_load", dut0.r_b, 4'hA);

      // Stack depth 2: overflow on the third nested CALL, then underflow RET.
      clear_prog();
      pim[0] = 'h2C; pim[2] = 'h4C; pim[4] = 'h6C; pim[6] = 'h0F;
      load1();
      rst1 = 1'b0;
      tick(); tick();
      chk("call2_ok", {se1, h1, dut1.r_sp, dut1.r_pc}, {1'b0, 1'b0, 2'd2, 4'h4});
      tick();
      chk("call_ovf", {se1, h1, dut1.r_sp, dut1.r_pc}, {1'b1, 1'b1, 2'd2, 4'h4});
      tick();
      chk("ovf_frozen", {se1, h1, dut1.r_sp, dut1.r_pc}, {1'b1, 1'b1, 2'd2, 4'h4});
      clear_prog();
      pim[0] = 'h0D;
      load1();
      rst1 = 1'b0;
      tick();
      chk("ret_udf", {se1, h1, dut1.r_sp, dut1.r_pc}, {1'b1, 1'b1, 2'd0, 4'h0});

      // 8-bit data, 32-entry memories.
      clear_prog();
      pdm[1] = 200; pdm[2] = 100;
      pim[0] = 'h11; pim[1] = 'h26; pim[2] = 'h03; pim[3] = 'h07;
      pim[4] = (31 << 4) | 9; pim[31] = 'h00; pim[5] = 'h0F;
      load2();
      rst2 = 1'b0;
      tick(); tick(); tick();
      chk("w8_add", {dut2.r_a, cf2, zf2}, {8'd44, 1'b1, 1'b0});
      tick();
      chk("w8_sub", {dut2.r_a, cf2, zf2}, {8'd200, 1'b1, 1'b0});
      tick();
      chk("w8_jmp31", dut2.r_pc, 5'd31);
      tick();
      chk("w8_pc_wrap", dut2.r_pc, 5'd0);

      // Random programs against the interpreter.
      for (int p = 0; p < 25; p++) begin
         for (int i = 0; i < 16; i++) begin
            pim[i] = int'($urandom_range(0, 255));
            pdm[i] = int'($urandom_range(0, 15));
            m_im[i] = pim[i];
            m_dm[i] = pdm[i];
         end
         load0();
         model_reset();
         rst0 = 1'b0;
         for (int c = 0; c < 40; c++) begin
            tick();
            model_step();
            chk($sformatf("rand_p%0d_c%0d", p, c), {dout0, zf0, cf0, h0, se0},
                {4'(m_dout), 1'(m_zf), 1'(m_cf), 1'(m_halt), 1'(m_serr)});
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
